// File: rtl/conv_window_ctrl_if.sv
// ---------------------------------------------------------------------------
// conv_window_ctrl_if
//   Pixel-in / window-out handshake bundle for the 3x3 convolution window
//   controller.
//
//   In_Valid   upstream pixel available
//   In_Ready   controller accepts a pixel this cycle
//   Shift_En   accept strobe (In_Valid & In_Ready) for line buffers / window regs
//   Out_Valid  a complete 3x3 window is present at the datapath output
//   Out_Ready  downstream consumes the window this cycle
//
//   master : the controller side
//   slave  : the surrounding datapath / environment side
// ---------------------------------------------------------------------------
interface conv_window_ctrl_if;
  logic In_Valid;
  logic In_Ready;
  logic Shift_En;
  logic Out_Valid;
  logic Out_Ready;

  modport master (
    input  In_Valid,
    input  Out_Ready,
    output In_Ready,
    output Shift_En,
    output Out_Valid
  );

  modport slave (
    output In_Valid,
    output Out_Ready,
    input  In_Ready,
    input  Shift_En,
    input  Out_Valid
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// ---------------------------------------------------------------------------
// conv_window_ctrl
//   Raster-scan controller for a 3x3 sliding-window convolution over a square
//   IMG_SIZE x IMG_SIZE image. Tracks the 1-based position of the last
//   accepted pixel, flags when a full window is present, and applies
//   backpressure so that no window is dropped or duplicated.
//
//   Parameters
//     DATA_WIDTH  width of the index counters and the window counter
//     IMG_SIZE    image edge length in pixels (3 .. 2**DATA_WIDTH-1)
//
//   Ports
//     Clk        clock, rising edge
//     Rst        asynchronous active-low reset
//     Start      begin a frame (sampled in IDLE only)
//     Clear      synchronous abort back to IDLE (highest priority)
//     stream     pixel/window handshake (conv_window_ctrl_if.master)
//     Col_Idx    1-based column of the last accepted pixel
//     Row_Idx    1-based row of the last accepted pixel
//     Busy       high in STREAM and DRAIN
//     Done       one-cycle frame-complete pulse
//     Win_Count  windows handed off in the current frame
//
//   Build option
//     CONV_WIN_CNT_EN  when defined, Win_Count counts handoffs; otherwise it
//                      is tied to zero and no counter is built.
// ---------------------------------------------------------------------------
module conv_window_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_SIZE   = 100
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic                  Clear,
  conv_window_ctrl_if.master    stream,
  output logic [DATA_WIDTH-1:0] Col_Idx,
  output logic [DATA_WIDTH-1:0] Row_Idx,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Win_Count
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] LAST  = DATA_WIDTH'(IMG_SIZE);
  localparam logic [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] THREE = DATA_WIDTH'(3);

  state_t                state;
  logic                  accept;
  logic                  handoff;
  logic                  win_hit;
  logic                  last_pix;
  logic [DATA_WIDTH-1:0] nxt_col;
  logic [DATA_WIDTH-1:0] nxt_row;

  // Backpressure: only take a new pixel if the window slot is empty or is
  // being drained this very cycle, so a window can never be overwritten.
  assign stream.In_Ready = (state == STREAM) && (!stream.Out_Valid || stream.Out_Ready);
  assign accept          = stream.In_Valid && stream.In_Ready;
  assign stream.Shift_En = accept;
  assign handoff         = stream.Out_Valid && stream.Out_Ready;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    nxt_col = Col_Idx + ONE;
    nxt_row = Row_Idx;
    // Column 0 only occurs before the first accept of a frame; both indices
    // then step 0 -> 1. Column IMG_SIZE wraps to 1 and advances the row.
    if (Col_Idx == '0 || Col_Idx == LAST) begin
      nxt_col = ONE;
      nxt_row = Row_Idx + ONE;
    end
    win_hit  = accept && (nxt_col >= THREE) && (nxt_row >= THREE);
    last_pix = accept && (nxt_col == LAST) && (nxt_row == LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state            <= IDLE;
      stream.Out_Valid <= 1'b0;
      Col_Idx          <= '0;
      Row_Idx          <= '0;
      Busy             <= 1'b0;
      Done             <= 1'b0;
    end else if (Clear) begin
      // Abort: indices are deliberately held for inspection until next Start.
      state            <= IDLE;
      stream.Out_Valid <= 1'b0;
      Busy             <= 1'b0;
      Done             <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (accept) begin
        Col_Idx <= nxt_col;
        Row_Idx <= nxt_row;
      end
      // A fresh window wins over a simultaneous handoff, keeping the slot full.
      if (win_hit)      stream.Out_Valid <= 1'b1;
      else if (handoff) stream.Out_Valid <= 1'b0;

      case (state)
        IDLE: begin
          if (Start) begin
            state   <= STREAM;
            Busy    <= 1'b1;
            Col_Idx <= '0;
            Row_Idx <= '0;
          end
        end
        STREAM: begin
          if (last_pix) state <= DRAIN;
        end
        DRAIN: begin
          if (!stream.Out_Valid || handoff) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONV_WIN_CNT_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Win_Count <= '0;
    end else if (Clear) begin
      Win_Count <= Win_Count;
    end else if (state == IDLE && Start) begin
      Win_Count <= '0;
    end else if (handoff) begin
      Win_Count <= Win_Count + ONE;
    end
  end
`else
  assign Win_Count = '0;
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_window_ctrl
//   Two controllers (IMG_SIZE 5 and 3) share one stimulus stream. A small
//   pixel-count model per instance predicts every output each cycle; pending
//   windows live in a scoreboard queue (pushed when a window-completing pixel
//   is accepted, popped on handoff).
// ---------------------------------------------------------------------------
module tb_conv_window_ctrl;
  localparam int DW = 16;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic start = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;

  always #5 Clk = ~Clk;

  conv_window_ctrl_if if5 ();
  conv_window_ctrl_if if3 ();

  assign if5.In_Valid  = in_valid;
  assign if5.Out_Ready = out_ready;
  assign if3.In_Valid  = in_valid;
  assign if3.Out_Ready = out_ready;

  logic [DW-1:0] col5, row5, win5, col3, row3, win3;
  logic          busy5, done5, busy3, done3;

  conv_window_ctrl #(.DATA_WIDTH(DW), .IMG_SIZE(5)) dut5 (
    .Clk(Clk), .Rst(Rst), .Start(start), .Clear(clear), .stream(if5.master),
    .Col_Idx(col5), .Row_Idx(row5), .Busy(busy5), .Done(done5), .Win_Count(win5)
  );

  conv_window_ctrl #(.DATA_WIDTH(DW), .IMG_SIZE(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .Start(start), .Clear(clear), .stream(if3.master),
    .Col_Idx(col3), .Row_Idx(row3), .Busy(busy3), .Done(done3), .Win_Count(win3)
  );

  // Index 0 -> IMG_SIZE 5, index 1 -> IMG_SIZE 3.
  logic [1:0]    o_rdy, o_sh, o_ov, o_busy, o_done;
  logic [DW-1:0] o_col [2];
  logic [DW-1:0] o_row [2];
  logic [DW-1:0] o_win [2];

  assign o_rdy  = {if3.In_Ready,  if5.In_Ready};
  assign o_sh   = {if3.Shift_En,  if5.Shift_En};
  assign o_ov   = {if3.Out_Valid, if5.Out_Valid};
  assign o_busy = {busy3, busy5};
  assign o_done = {done3, done5};
  assign o_col[0] = col5;
  assign o_col[1] = col3;
  assign o_row[0] = row5;
  assign o_row[1] = row3;
  assign o_win[0] = win5;
  assign o_win[1] = win3;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int NN [2] = '{5, 3};
  int st   [2];   // 0 idle, 1 stream, 2 drain, 3 done
  int k    [2];   // pixels accepted this frame
  int mcol [2];
  int mrow [2];
  int wins [2];
  int sb_q [2][$];
  int hc   [2];   // handoffs observed on the DUT this frame
  int ac   [2];   // accepts observed on the DUT this frame

  task automatic mon_step(input int d);
    string p;
    bit    e_ov, e_rdy, e_sh, ho;
    int    e_win;
    int    n;
    n = NN[d];
    p = $sformatf("n%0d", n);
    if (!Rst) begin
      st[d] = 0; k[d] = 0; mcol[d] = 0; mrow[d] = 0; wins[d] = 0;
      sb_q[d].delete();
    end
    e_ov  = (sb_q[d].size() != 0);
    e_rdy = Rst && (st[d] == 1) && (!e_ov || out_ready);
    e_sh  = e_rdy && in_valid;
`ifdef CONV_WIN_CNT_EN
    e_win = wins[d];
`else
    e_win = 0;
`endif
    check({p, ".in_ready"},  o_rdy[d],  e_rdy);
    check({p, ".shift_en"},  o_sh[d],   e_sh);
    check({p, ".out_valid"}, o_ov[d],   e_ov);
    check({p, ".busy"},      o_busy[d], (st[d] == 1 || st[d] == 2));
    check({p, ".done"},      o_done[d], (st[d] == 3));
    check({p, ".col"},       o_col[d],  mcol[d]);
    check({p, ".row"},       o_row[d],  mrow[d]);
    check({p, ".win_count"}, o_win[d],  e_win);
    if (!Rst) return;

    hc[d] += int'(o_ov[d] && out_ready);
    ac[d] += int'(o_sh[d]);

    ho = e_ov && out_ready;
    if (clear) begin
      st[d] = 0;
      sb_q[d].delete();
    end else begin
      case (st[d])
        0: if (start) begin
             st[d] = 1; k[d] = 0; mcol[d] = 0; mrow[d] = 0; wins[d] = 0;
           end
        1: begin
             if (ho) begin void'(sb_q[d].pop_front()); wins[d]++; end
             if (e_sh) begin
               k[d]++;
               mcol[d] = (k[d] - 1) % n + 1;
               mrow[d] = (k[d] - 1) / n + 1;
               if (mrow[d] >= 3 && mcol[d] >= 3) sb_q[d].push_back(mrow[d] * 256 + mcol[d]);
               if (k[d] == n * n) st[d] = 2;
             end
           end
        2: begin
             if (ho) begin void'(sb_q[d].pop_front()); wins[d]++; end
             if (!e_ov || ho) st[d] = 3;
           end
        default: st[d] = 0;
      endcase
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      st[d] = 0; k[d] = 0; mcol[d] = 0; mrow[d] = 0; wins[d] = 0; hc[d] = 0; ac[d] = 0;
    end
    forever begin
      @(negedge Clk);
      for (int d = 0; d < 2; d++) mon_step(d);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_frame();
    @(posedge Clk); #1;
    start = 1'b1;
    hc = '{0, 0};
    ac = '{0, 0};
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit toggle);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (o_done[0]) begin seen = 1'b1; break; end
      @(posedge Clk); #1;
      if (toggle) in_valid = ~in_valid;
    end
    check("timeout.done", seen, 1);
  endtask

  task automatic wait_ov();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (o_ov[0]) begin seen = 1'b1; break; end
    end
    check("timeout.out_valid", seen, 1);
  endtask

  task automatic frame_checks(input string tag);
    check({tag, ".n5.handoffs"}, hc[0], 9);
    check({tag, ".n3.handoffs"}, hc[1], 1);
    check({tag, ".n5.accepts"},  ac[0], 25);
    check({tag, ".n3.accepts"},  ac[1], 9);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    repeat (2) @(negedge Clk);
    check("reset.n5.in_ready", o_rdy[0], 0);
    check("reset.n5.col", o_col[0], 0);
    @(posedge Clk); #1;
    Rst = 1'b1;

    // Continuous streaming, no backpressure.
    in_valid = 1'b1; out_ready = 1'b1;
    start_frame();
    wait_done(1'b0);
    frame_checks("stream");

    // Downstream stalls at the first window for 4 cycles.
    out_ready = 1'b0;
    start_frame();
    wait_ov();
    for (int i = 0; i < 4; i++) begin
      check("stall.n5.col", o_col[0], 3);
      check("stall.n5.row", o_row[0], 3);
      check("stall.n5.in_ready", o_rdy[0], 0);
      @(negedge Clk);
    end
    @(posedge Clk); #1;
    out_ready = 1'b1;
    wait_done(1'b0);
    frame_checks("stall");

    // Upstream bubbles every other cycle.
    in_valid = 1'b0;
    start_frame();
    wait_done(1'b1);
    frame_checks("bubble");

    // Abort with Clear on row 4, then a clean frame.
    in_valid = 1'b1;
    start_frame();
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge Clk);
        if (o_row[0] == 4) begin seen = 1'b1; break; end
      end
      check("timeout.row4", seen, 1);
    end
    @(posedge Clk); #1; clear = 1'b1;
    @(posedge Clk); #1; clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("clear.n5.busy", o_busy[0], 0);
      check("clear.n5.out_valid", o_ov[0], 0);
      check("clear.n5.done", o_done[0], 0);
    end
    start_frame();
    wait_done(1'b0);
    frame_checks("after_clear");

    // Start while busy is ignored; reset mid-frame with a window pending.
    start_frame();
    wait_ov();
    @(posedge Clk); #1; start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
    #2 Rst = 1'b0;
    #1;
    check("async_rst.in_ready",  o_rdy[0],  0);
    check("async_rst.shift_en",  o_sh[0],   0);
    check("async_rst.out_valid", o_ov[0],   0);
    check("async_rst.busy",      o_busy[0], 0);
    check("async_rst.done",      o_done[0], 0);
    check("async_rst.col",       o_col[0],  0);
    check("async_rst.row",       o_row[0],  0);
    check("async_rst.win_count", o_win[0],  0);
    @(posedge Clk); #1; Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("post_rst.n5.busy", o_busy[0], 0);
    end
    start_frame();
    wait_done(1'b0);
    frame_checks("after_rst");

    repeat (3) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 16, width of the row/column index counters and the window counter.
REQ-002 Parameter: IMG_SIZE, 100, square image edge length in pixels; legal range 3..2^DATA_WIDTH-1.
REQ-003 Port: Clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: Rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: Start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
REQ-006 Port: Clear  input  1  synchronous abort; returns to IDLE.
REQ-007 Port: In_Valid  input  1  upstream pixel available.
REQ-008 Port: In_Ready  output  1  controller accepts a pixel this cycle; accept = In_Valid & In_Ready.
REQ-009 Port: Shift_En  output  1  combinational copy of accept; drives line-buffer and window-register shift enables.
REQ-010 Port: Out_Valid  output  1  a complete 3x3 window is present at the datapath output.
REQ-011 Port: Out_Ready  input  1  downstream consumes the window when Out_Valid & Out_Ready.
REQ-012 Port: Col_Idx  output  DATA_WIDTH  1-based column of the last accepted pixel; 0 before the first accept.
REQ-013 Port: Row_Idx  output  DATA_WIDTH  1-based row of the last accepted pixel; 0 before the first accept.
REQ-014 Port: Busy  output  1  high in STREAM and DRAIN.
REQ-015 Port: Done  output  1  one-cycle pulse at frame completion.
REQ-016 Port: Win_Count  output  DATA_WIDTH  number of windows handed off in the current frame (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, STREAM, DRAIN, and DONE.
REQ-018 IDLE -> STREAM on Start; the transition SHALL zero Col_Idx, Row_Idx, and Win_Count.
REQ-019 In_Ready SHALL be 1 only in STREAM and only when (!Out_Valid | Out_Ready); it is 0 in every other state.
REQ-020 On accept, Col_Idx SHALL increment; at IMG_SIZE it SHALL wrap to 1 and Row_Idx SHALL increment; on the first accept of a frame both indices SHALL become 1.
REQ-021 Window-valid condition on accept: new Col_Idx >= 3 and new Row_Idx >= 3.
REQ-022 Out_Valid SHALL be set the cycle after an accept that meets REQ-021, giving 1-cycle latency.
REQ-023 Out_Valid SHALL clear after a handoff (Out_Valid & Out_Ready) with no new valid accept in the same cycle; a simultaneous handoff and valid accept SHALL keep Out_Valid at 1.
REQ-024 Out_Valid SHALL hold while Out_Ready is 0; no window is dropped or duplicated.
REQ-025 Accepting pixel (IMG_SIZE, IMG_SIZE) SHALL move STREAM -> DRAIN.
REQ-026 DRAIN -> DONE once Out_Valid is 0 or is handed off; DONE lasts exactly 1 cycle with Done=1, then -> IDLE.
REQ-027 Start SHALL be ignored outside IDLE.
REQ-028 Clear SHALL take priority over all other events in any state: -> IDLE next cycle, Out_Valid=0, Done not pulsed, indices and counter held until the next Start.
REQ-029 In_Valid with In_Ready=0 SHALL be ignored; indices SHALL not move.
REQ-030 A full frame SHALL produce exactly (IMG_SIZE-2)^2 handoffs.

Reset
REQ-031 Rst low SHALL immediately force: state IDLE, In_Ready=0, Shift_En=0, Out_Valid=0, Busy=0, Done=0, Col_Idx=0, Row_Idx=0, Win_Count=0.
REQ-032 Rst asserted mid-frame SHALL discard the frame; after release the block SHALL wait in IDLE for Start.

Configuration
REQ-033 Macro CONV_WIN_CNT_EN defined: Win_Count SHALL increment by 1 on each handoff and hold its final value after DONE until the next Start.
REQ-034 Macro CONV_WIN_CNT_EN undefined: Win_Count SHALL be tied to 0 and no counter logic SHALL be built; all other behaviour is unchanged.

Verification (IMG_SIZE=5 unless stated)
REQ-035 Start, In_Valid=1 continuous, Out_Ready=1 -> 25 accepts in 25 cycles, 9 Out_Valid handoffs, first handoff the cycle after pixel (3,3), Done one cycle after the final handoff, Win_Count=9 with the macro defined.
REQ-036 Out_Ready=0 for 4 cycles at the first window -> Out_Valid held, In_Ready=0, indices frozen at (3,3); release -> stream resumes with no loss, total 9 handoffs.
REQ-037 In_Valid toggled 1/0 every cycle -> indices advance only on accepts, wrap 5->1 with Row_Idx increment, 9 handoffs.
REQ-038 Clear asserted while Row_Idx=4 -> IDLE next cycle, Out_Valid=0, no Done; a new Start gives a clean 9-window frame.
REQ-039 Rst pulsed mid-frame with Out_Valid=1 -> all outputs 0 asynchronously; Start during Busy is ignored (frame count unchanged).
REQ-040 IMG_SIZE=3 -> exactly 1 handoff after the 9th pixel; macro undefined -> Win_Count constant 0.
